// File: rtl/gam_edge_age_ctrl_pkg.sv
// Shared types and constants for the GAM edge-aging controller and its
// connection-memory port.
package gam_edge_age_ctrl_pkg;

    localparam int NODE_COUNT  = 10;
    localparam int CLASS_COUNT = 4;
    localparam int AGE_MAX     = 6;
    localparam int AGE_W       = 8;
    localparam int NIDX_W      = $clog2(NODE_COUNT + 1);
    localparam int CIDX_W      = $clog2(CLASS_COUNT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK,
        S_WAIT_GNT,
        S_RD,
        S_RD_WAIT,
        S_WR_FWD,
        S_WR_REV,
        S_NEXT,
        S_LINK_FWD,
        S_LINK_REV,
        S_DONE
    } edge_age_state_T;

    typedef struct packed {
        logic             presence;
        logic [AGE_W-1:0] age;
    } conn_word_T;

    typedef conn_word_T connection_mem_T [1:CLASS_COUNT][1:NODE_COUNT][1:NODE_COUNT];

    // One aging step of a present edge: survivors get age+1, anything that
    // would exceed AGE_MAX collapses to an all-zero (deleted) word.
    function automatic conn_word_T age_step(conn_word_T rd_word);
        conn_word_T res;
        res = '0;
        if (rd_word.age < AGE_W'(AGE_MAX)) begin
            res.presence = 1'b1;
            res.age      = rd_word.age + 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/gam_edge_age_ctrl_if.sv
// Connection-memory access port: ownership req/gnt, strobes, address and data.
interface gam_edge_age_ctrl_if;
    import gam_edge_age_ctrl_pkg::*;

    logic              req;
    logic              gnt;
    logic              rd;
    logic              wr;
    logic [CIDX_W-1:0] class_sel;
    logic [NIDX_W-1:0] row;
    logic [NIDX_W-1:0] col;
    conn_word_T        wdata;
    conn_word_T        rdata;

    modport master (
        output req, rd, wr, class_sel, row, col, wdata,
        input  gnt, rdata
    );

    modport slave (
        input  req, rd, wr, class_sel, row, col, wdata,
        output gnt, rdata
    );

endinterface

// File: rtl/gam_edge_age_ctrl.sv
// Per-class edge aging: ages every edge incident on the winner, deletes
// over-age edges, then (re)creates the winner-second edge at age 0.
module gam_edge_age_ctrl
    import gam_edge_age_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CIDX_W-1:0]   class_id,
    input  logic [NIDX_W-1:0]   winner,
    input  logic [NIDX_W-1:0]   second,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [NIDX_W-1:0]   removed_cnt,
    gam_edge_age_ctrl_if.master mem
);

    edge_age_state_T   state_reg, state_next;
    logic [CIDX_W-1:0] cls_reg;
    logic [NIDX_W-1:0] win_reg;
    logic [NIDX_W-1:0] sec_reg;
    logic [NIDX_W-1:0] j_reg;
    conn_word_T        wword_reg;
    logic [NIDX_W-1:0] removed_reg;
    logic              err_reg;

    logic              args_bad;
    logic [NIDX_W-1:0] j_first;
    logic [NIDX_W:0]   j_adv;
    logic              j_last;
    conn_word_T        aged_word;

    assign args_bad = (win_reg == sec_reg) ||
                      (win_reg == '0) || (sec_reg == '0) || (cls_reg == '0) ||
                      (win_reg > NIDX_W'(NODE_COUNT)) ||
                      (sec_reg > NIDX_W'(NODE_COUNT)) ||
                      (cls_reg > CIDX_W'(CLASS_COUNT));

    // The scan never visits the winner's own column.
    assign j_first = (win_reg == NIDX_W'(1)) ? NIDX_W'(2) : NIDX_W'(1);

    always_comb begin
        j_adv = {1'b0, j_reg} + 1'b1;
        if (j_adv == {1'b0, win_reg}) begin
            j_adv = j_adv + 1'b1;
        end
    end

    assign j_last    = (j_adv > (NIDX_W + 1)'(NODE_COUNT));
    assign aged_word = age_step(mem.rdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        mem.req       = 1'b0;
        mem.rd        = 1'b0;
        mem.wr        = 1'b0;
        mem.class_sel = '0;
        mem.row       = '0;
        mem.col       = '0;
        mem.wdata     = '0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_CHK;
            end
            S_CHK: begin
                state_next = args_bad ? S_DONE : S_WAIT_GNT;
            end
            S_WAIT_GNT: begin
                mem.req = 1'b1;
                if (mem.gnt) state_next = S_RD;
            end
            S_RD: begin
                mem.req       = 1'b1;
                mem.class_sel = cls_reg;
                mem.row       = win_reg;
                mem.col       = j_reg;
                if (mem.gnt) begin
                    mem.rd     = 1'b1;
                    state_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                mem.req    = 1'b1;
                state_next = mem.rdata.presence ? S_WR_FWD : S_NEXT;
            end
            S_WR_FWD, S_WR_REV: begin
                mem.req       = 1'b1;
                mem.class_sel = cls_reg;
                mem.row       = (state_reg == S_WR_FWD) ? win_reg : j_reg;
                mem.col       = (state_reg == S_WR_FWD) ? j_reg : win_reg;
                mem.wdata     = wword_reg;
                if (mem.gnt) begin
                    mem.wr     = 1'b1;
                    state_next = (state_reg == S_WR_FWD) ? S_WR_REV : S_NEXT;
                end
            end
            S_NEXT: begin
                mem.req    = 1'b1;
                state_next = j_last ? S_LINK_FWD : S_RD;
            end
            S_LINK_FWD, S_LINK_REV: begin
                mem.req            = 1'b1;
                mem.class_sel      = cls_reg;
                mem.row            = (state_reg == S_LINK_FWD) ? win_reg : sec_reg;
                mem.col            = (state_reg == S_LINK_FWD) ? sec_reg : win_reg;
                mem.wdata.presence = 1'b1;
                if (mem.gnt) begin
                    mem.wr     = 1'b1;
                    state_next = (state_reg == S_LINK_FWD) ? S_LINK_REV : S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_reg     <= '0;
            win_reg     <= '0;
            sec_reg     <= '0;
            j_reg       <= '0;
            wword_reg   <= '0;
            removed_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cls_reg     <= class_id;
                        win_reg     <= winner;
                        sec_reg     <= second;
                        removed_reg <= '0;
                        err_reg     <= 1'b0;
                    end
                end
                S_CHK: begin
                    err_reg <= args_bad;
                    j_reg   <= j_first;
                end
                S_RD_WAIT: begin
                    if (mem.rdata.presence) begin
                        wword_reg <= aged_word;
                        if (!aged_word.presence) removed_reg <= removed_reg + 1'b1;
                    end
                end
                S_NEXT: begin
                    j_reg <= j_adv[NIDX_W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);
    assign err         = done && err_reg;
    assign removed_cnt = removed_reg;

endmodule

// File: tb/tb_gam_edge_age_ctrl.sv
// Randomised bench for gam_edge_age_ctrl against a behavioural memory and
// aging model.
module tb_gam_edge_age_ctrl;
    import gam_edge_age_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CIDX_W-1:0] class_id;
    logic [NIDX_W-1:0] winner;
    logic [NIDX_W-1:0] second;
    logic              busy, done, err;
    logic [NIDX_W-1:0] removed_cnt;

    gam_edge_age_ctrl_if mbus();

    gam_edge_age_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .class_id   (class_id),
        .winner     (winner),
        .second     (second),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .removed_cnt(removed_cnt),
        .mem        (mbus)
    );

    always #5 clk = ~clk;

    connection_mem_T ram;
    connection_mem_T exp_mem;
    int  checks = 0;
    int  errors = 0;
    int  rd_cnt, wr_cnt, viol_cnt, req_cyc;
    bit  req_seen;
    int  gnt_mode;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Memory slave: samples strobes at the edge, answers reads a cycle later.
    logic              s_rd, s_wr;
    int                s_c, s_r, s_col;
    conn_word_T        s_wd;
    always @(posedge clk) begin
        s_rd  = mbus.rd && mbus.gnt;
        s_wr  = mbus.wr && mbus.gnt;
        s_c   = int'(mbus.class_sel);
        s_r   = int'(mbus.row);
        s_col = int'(mbus.col);
        s_wd  = mbus.wdata;
        if ((mbus.rd || mbus.wr) && !mbus.gnt) viol_cnt++;
        if (mbus.req) req_seen = 1'b1;
        if (s_rd) rd_cnt++;
        if (s_wr) wr_cnt++;
        #1;
        if (s_c >= 1 && s_c <= CLASS_COUNT && s_r >= 1 && s_r <= NODE_COUNT &&
            s_col >= 1 && s_col <= NODE_COUNT) begin
            if (s_rd) mbus.rdata = ram[s_c][s_r][s_col];
            if (s_wr) ram[s_c][s_r][s_col] = s_wd;
        end else if (s_rd) begin
            mbus.rdata = '0;
        end
    end

    // Grant source: 0 tied high, 1 random, 2 scripted stalls.
    always @(posedge clk) begin
        #1;
        if (mbus.req) req_cyc++;
        else req_cyc = 0;
        case (gnt_mode)
            0: mbus.gnt = 1'b1;
            1: mbus.gnt = ($urandom_range(0, 3) != 0);
            default: mbus.gnt = !((req_cyc >= 1 && req_cyc <= 5) ||
                                  (req_cyc >= 15 && req_cyc <= 17));
        endcase
    end

    task automatic model_run(input int c, input int w, input int s,
                             output bit valid, output int rem, output int k);
        conn_word_T e;
        int na;
        rem = 0;
        k   = 0;
        valid = (w != s) && (w >= 1) && (w <= NODE_COUNT) && (s >= 1) && (s <= NODE_COUNT) &&
                (c >= 1) && (c <= CLASS_COUNT);
        if (!valid) return;
        for (int j = 1; j <= NODE_COUNT; j++) begin
            if (j != w && exp_mem[c][w][j].presence) begin
                k++;
                na = int'(exp_mem[c][w][j].age) + 1;
                e = '0;
                if (na > AGE_MAX) rem++;
                else begin
                    e.presence = 1'b1;
                    e.age      = AGE_W'(na);
                end
                exp_mem[c][w][j] = e;
                exp_mem[c][j][w] = e;
            end
        end
        e = '0;
        e.presence = 1'b1;
        exp_mem[c][w][s] = e;
        exp_mem[c][s][w] = e;
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int c = 1; c <= CLASS_COUNT; c++)
            for (int i = 1; i <= NODE_COUNT; i++)
                for (int j = 1; j <= NODE_COUNT; j++)
                    if (ram[c][i][j] !== exp_mem[c][i][j]) n++;
        return n;
    endfunction

    task automatic set_edge(input int c, input int a, input int b, input bit p, input int age);
        conn_word_T e;
        e.presence = p;
        e.age      = AGE_W'(age);
        ram[c][a][b] = e;
        ram[c][b][a] = e;
    endtask

    task automatic init_ram(input bit empty);
        for (int c = 1; c <= CLASS_COUNT; c++)
            for (int i = 1; i <= NODE_COUNT; i++) begin
                ram[c][i][i] = '0;
                for (int j = i + 1; j <= NODE_COUNT; j++)
                    set_edge(c, i, j, empty ? 1'b0 : 1'($urandom_range(0, 1)),
                             empty ? 0 : int'($urandom_range(0, AGE_MAX + 2)));
            end
    endtask

    task automatic run_op(input int c, input int w, input int s, input int intr_cyc);
        bit valid;
        int rem, k, cyc;
        exp_mem = ram;
        model_run(c, w, s, valid, rem, k);
        rd_cnt = 0; wr_cnt = 0; viol_cnt = 0; req_seen = 1'b0;
        @(posedge clk); #2;
        start    = 1'b1;
        class_id = c[CIDX_W-1:0];
        winner   = w[NIDX_W-1:0];
        second   = s[NIDX_W-1:0];
        cyc = 0;
        while (1) begin
            @(posedge clk); #2;
            cyc++;
            start = (cyc == intr_cyc);
            if (cyc == intr_cyc) winner = NIDX_W'(9);
            if (cyc == 1) check_val("busy_run", 32'(busy), 1);
            if (done) break;
            if (cyc > 3000) begin
                check_val("done_timeout", 32'(cyc), 0);
                return;
            end
        end
        $display("op class=%0d w=%0d s=%0d mode=%0d cycles=%0d err=%0d removed=%0d",
                 c, w, s, gnt_mode, cyc, err, removed_cnt);
        check_val("err", 32'(err), 32'(!valid));
        check_val("removed", 32'(removed_cnt), 32'(rem));
        if (gnt_mode == 0) check_val("latency", 32'(cyc), valid ? 32'(32 + 2 * k) : 32'd2);
        check_val("reads", 32'(rd_cnt), valid ? 32'(NODE_COUNT - 1) : 32'd0);
        check_val("writes", 32'(wr_cnt), valid ? 32'(2 * k + 2) : 32'd0);
        check_val("strobe_no_gnt", 32'(viol_cnt), 0);
        check_val("req_seen", 32'(req_seen), 32'(valid));
        check_val("mem_diff", 32'(mem_diff()), 0);
        @(posedge clk); #2;
        check_val("busy_after", 32'(busy), 0);
        check_val("removed_held", 32'(removed_cnt), 32'(rem));
    endtask

    initial begin
        int c, w, s, cyc;
        rst = 1'b1; start = 1'b0; class_id = '0; winner = '0; second = '0;
        mbus.gnt = 1'b0; mbus.rdata = '0; gnt_mode = 0; req_cyc = 0;
        init_ram(1'b1);
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_req", 32'(mbus.req), 0);
        check_val("rst_removed", 32'(removed_cnt), 0);
        rst = 1'b0;

        // Empty class
        run_op(2, 3, 5, 0);
        check_val("link_fwd", 32'(ram[2][3][5]), 32'(1 << AGE_W));
        check_val("link_rev", 32'(ram[2][5][3]), 32'(1 << AGE_W));

        // Aging, deletion and link refresh
        init_ram(1'b1);
        set_edge(1, 3, 1, 1'b1, 2);
        set_edge(1, 3, 7, 1'b1, 6);
        set_edge(1, 3, 5, 1'b1, 4);
        run_op(1, 3, 5, 0);
        check_val("e31_age", 32'(ram[1][1][3].age), 3);
        check_val("e37_pres", 32'(ram[1][7][3].presence), 0);
        check_val("e35_age", 32'(ram[1][3][5].age), 0);

        // Bad arguments
        run_op(1, 4, 4, 0);

        // Grant stalls
        init_ram(1'b0);
        gnt_mode = 2;
        run_op(3, 6, 2, 0);
        gnt_mode = 0;

        // Reset during the forward write of column 6
        init_ram(1'b0);
        set_edge(1, 2, 6, 1'b1, 1);
        @(posedge clk); #2;
        start = 1'b1; class_id = CIDX_W'(1); winner = NIDX_W'(2); second = NIDX_W'(8);
        cyc = 0;
        while (!(mbus.wr && mbus.row == NIDX_W'(2) && mbus.col == NIDX_W'(6)) && cyc < 200) begin
            @(posedge clk); #2;
            start = 1'b0;
            cyc++;
        end
        check_val("wr_fwd6_reached", 32'(cyc < 200), 1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy), 0);
        check_val("mid_rst_wr", 32'(mbus.wr), 0);
        check_val("mid_rst_req", 32'(mbus.req), 0);
        @(posedge clk); #2;
        check_val("mid_rst_done", 32'(done), 0);
        check_val("mid_rst_removed", 32'(removed_cnt), 0);
        rst = 1'b0;
        init_ram(1'b0);
        run_op(4, 1, 10, 0);

        // Start while busy is ignored
        run_op(1, 2, 7, 5);

        for (int n = 0; n < 25; n++) begin
            if (n % 5 == 0) init_ram(1'b0);
            gnt_mode = int'($urandom_range(0, 1));
            c = int'($urandom_range(1, CLASS_COUNT));
            w = int'($urandom_range(1, NODE_COUNT));
            s = int'($urandom_range(1, NODE_COUNT));
            if (s == w) s = (w % NODE_COUNT) + 1;
            case ($urandom_range(0, 9))
                0: c = 0;
                1: c = CLASS_COUNT + 1;
                2: w = NODE_COUNT + 1;
                3: s = w;
                4: s = 0;
                default: ;
            endcase
            run_op(c, w, s, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
